flow_combiner_rx: RTL and testbench
===================================

Name: flow_combiner_rx

Overview:
- Receive-side inverse of the TX flow distributor.
- Accepts pairs of descrambled 257-bit blocks (flow_0, flow_1) and re-serialises them into a single block stream: flow_0 block first, then flow_1 block.
- Sits between the two RX descramblers and the block checker/sink.
- Input pairs can arrive faster than one block per cycle is drained, so the block contains an elastic pair FIFO with backpressure and a sticky overflow flag.

Parameters:
- BITS_BLOCK, 257, width of one block.
- FIFO_DEPTH, 4, pair entries in the elastic buffer; power of 2, minimum 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  single clock domain.
- rst  input  1  synchronous reset, active-high.
- i_valid  input  1  flow_0/flow_1 hold a valid pair this cycle.
- flow_0  input  BITS_BLOCK  block from flow 0; emitted first.
- flow_1  input  BITS_BLOCK  block from flow 1; emitted second.
- o_ready  output  1  FIFO not full; a pair offered this cycle is accepted.
- i_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  BITS_BLOCK  re-serialised block.
- valid  output  1  data_out holds a valid block.
- overflow  output  1  sticky; set when a pair is dropped.
- fifo_level  output  CNT_W  pairs currently stored, 0..FIFO_DEPTH.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - data_out=0, valid=0, overflow=0, fifo_level=0, o_ready=1.
  - FIFO pointers cleared, phase bit sel=0.
  - Reset mid-stream discards all stored pairs and any half-emitted pair; there is no flush.
- o_ready = (fifo_level != FIFO_DEPTH). It is combinational from registered state only, with no path from i_valid or i_ready.
- Write: at an edge with i_valid=1 and o_ready=1, {flow_1, flow_0} is pushed and fifo_level increments.
- Drop: at an edge with i_valid=1 and o_ready=0, the pair is discarded and overflow is set to 1. overflow holds until rst.
  - A write to a full FIFO is rejected even if a pop occurs at the same edge.
- Output register load condition: load_en = (!valid || i_ready).
  - load_en=1 and FIFO non-empty: data_out <= sel ? head.flow_1 : head.flow_0; valid <= 1; sel toggles.
    - The head entry pops (fifo_level decrements, read pointer advances) only when loading with sel=1.
  - load_en=1 and FIFO empty: valid <= 0; data_out holds its last value.
  - load_en=0: data_out, valid and sel hold. Stalls are lossless.
- Simultaneous push and pop at one edge: fifo_level is unchanged and both pointers advance.
- Latency:
  - A pair accepted at edge E into an empty FIFO with i_ready=1 presents flow_0 on data_out after edge E+1 and flow_1 after edge E+2.
  - The head is read from registered FIFO storage, so there is no same-edge bypass.
- Throughput:
  - 1 block/cycle out, i.e. 1 pair per 2 cycles.
  - Sustained i_valid on every cycle fills the FIFO and then drops pairs.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full and empty are decided by fifo_level, not by pointer compare.
- Ordering invariant: the output sequence is f0[0], f1[0], f0[1], f1[1], … for accepted pairs, with no reordering. sel is never left at 1 when the FIFO empties mid-pair, because the pop occurs only on the flow_1 load.

Decomposition:
- Package aui_rx_pkg:
  - BITS_BLOCK localparam.
  - typedef logic [BITS_BLOCK-1:0] block_t.
  - typedef struct packed {block_t flow_1; block_t flow_0;} block_pair_t.
- Sub-module sync_fifo_pair: parameterised synchronous FIFO of block_pair_t.
  - Interface: push, pop, head, level.
  - Registered storage and no overflow logic; drop policy lives in the top.
- Top flow_combiner_rx holds the push/drop decision, the sel phase FSM (EMIT_F0 / EMIT_F1), the output register and the overflow flag.

Test Plan:
1. Reset sequencing: hold rst 3 cycles with i_valid=1 → valid=0, data_out=0, fifo_level=0, o_ready=1, overflow=0 throughout; no pair is stored.
2. Single pair: flow_0=257'h1, flow_1=257'h2, i_valid for 1 cycle at edge E, i_ready=1 → data_out=1 with valid after E+1, data_out=2 after E+2, valid=0 after E+3, fifo_level back to 0.
3. Paced stream: 100 pairs (f0=2k, f1=2k+1), i_valid every 2nd cycle, i_ready=1 → output is contiguous 0..199 in order, valid continuous once started, overflow=0, fifo_level ≤1.
4. Overrun: i_valid every cycle for 12 cycles, i_ready=1, FIFO_DEPTH=4 → o_ready drops to 0, excess pairs are dropped, overflow=1 and sticky; every emitted pair is an intact, ordered accepted pair.
5. Backpressure stall: hold i_ready=0 for 5 cycles while flow_1 of a pair is on data_out → data_out and valid unchanged; on release, the next pair's flow_0 appears after 1 edge with no loss or duplication.
6. Reset mid-operation: assert rst with fifo_level=3 and sel=1 → after 1 edge, fifo_level=0, valid=0, sel=0; a subsequent pair emits flow_0 first.

Source files
------------

// File: rtl/aui_rx_pkg.sv
// Shared types for the AUI receive path.
//   BITS_BLOCK    : width of one descrambled block
//   block_t       : one block
//   block_pair_t  : one flow_0/flow_1 pair, flow_0 in the low half
//   emit_phase_e  : which half of the head pair goes out next
package aui_rx_pkg;

  localparam int BITS_BLOCK = 257;

  typedef logic [BITS_BLOCK-1:0] block_t;

  typedef struct packed {
    block_t flow_1;
    block_t flow_0;
  } block_pair_t;

  typedef enum logic {
    EMIT_F0 = 1'b0,
    EMIT_F1 = 1'b1
  } emit_phase_e;

endpackage

// File: rtl/flow_combiner_rx_if.sv
// Handshake bundle of flow_combiner_rx.
//   master : pair source and block sink (i_valid, flow_0, flow_1, i_ready out)
//   slave  : the combiner (o_ready, data_out, valid, overflow, fifo_level out)
interface flow_combiner_rx_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
  import aui_rx_pkg::*;

  logic             i_valid;
  block_t           flow_0;
  block_t           flow_1;
  logic             o_ready;
  logic             i_ready;
  block_t           data_out;
  logic             valid;
  logic             overflow;
  logic [CNT_W-1:0] fifo_level;

  modport master (
    output i_valid, flow_0, flow_1, i_ready,
    input  o_ready, data_out, valid, overflow, fifo_level
  );

  modport slave (
    input  i_valid, flow_0, flow_1, i_ready,
    output o_ready, data_out, valid, overflow, fifo_level
  );

endinterface

// File: rtl/sync_fifo_pair.sv
// Synchronous FIFO of block pairs with registered storage.
//   clk, rst   : clock, synchronous active-high reset
//   push/data  : write push_data at the edge (caller never pushes when full)
//   pop        : advance the head at the edge (caller never pops when empty)
//   head       : entry at the read pointer, read from storage (no bypass)
//   level      : entries stored, 0..DEPTH
module sync_fifo_pair
  import aui_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  block_pair_t      push_data,
  input  logic             pop,
  output block_pair_t      head,
  output logic [CNT_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  block_pair_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage is deliberately not reset; level gates every read, so stale
  // contents are never observed and the wide array stays plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers wrap naturally at DEPTH (power of two); full/empty come from level.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/flow_combiner_rx.sv
// Re-serialises descrambled flow_0/flow_1 block pairs into one block stream
// (flow_0 first, then flow_1) through an elastic pair FIFO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of flow_combiner_rx_if
//              in : i_valid, flow_0, flow_1 (pair offer), i_ready (sink ready)
//              out: o_ready (FIFO not full), data_out/valid (block stream),
//                   overflow (sticky pair drop), fifo_level (pairs stored)
module flow_combiner_rx
  import aui_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  flow_combiner_rx_if.slave  bus
);

  block_pair_t      push_data;
  block_pair_t      head;
  logic [CNT_W-1:0] level;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             load;
  logic             load_en;

  emit_phase_e      state_q;
  emit_phase_e      state_d;
  block_t           data_q;
  logic             valid_q;
  logic             overflow_q;

  // Full/empty depend on registered level only, so o_ready has no path from
  // i_valid or i_ready. A full FIFO rejects a write even if it pops this edge.
  assign full      = (level == CNT_W'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign push      = bus.i_valid && !full;
  assign push_data = '{flow_1: bus.flow_1, flow_0: bus.flow_0};
  assign load_en   = !valid_q || bus.i_ready;

  sync_fifo_pair #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMIT_F0;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    if (load_en && !empty) begin
      load = 1'b1;
      unique case (state_q)
        EMIT_F0: state_d = EMIT_F1;
        EMIT_F1: begin
          // The head leaves the FIFO only once its flow_1 half is taken, so a
          // half-emitted pair is never lost and sel never strands at EMIT_F1.
          state_d = EMIT_F0;
          pop     = 1'b1;
        end
        default: state_d = EMIT_F0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= (state_q == EMIT_F1) ? head.flow_1 : head.flow_0;
        valid_q <= 1'b1;
      end else if (load_en) begin
        // Sink took the block and nothing is queued: go idle, keep data.
        valid_q <= 1'b0;
      end
      if (bus.i_valid && full) overflow_q <= 1'b1;
    end
  end

  assign bus.o_ready    = !full;
  assign bus.data_out   = data_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_flow_combiner_rx.sv
// Self-checking bench for flow_combiner_rx: directed table, hand-written
// corner sequences, and randomized traffic against a block-queue model.
module tb_flow_combiner_rx;
  import aui_rx_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;

  flow_combiner_rx_if #(.FIFO_DEPTH(DEPTH)) bus();

  flow_combiner_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: blocks still waiting to be loaded, in emission order.
  // A pair stays stored until both halves are loaded, so level = ceil(size/2).
  block_t bq[$];
  logic   m_valid;
  block_t m_data;
  logic   m_ovf;

  task automatic check(input string name, input logic [BITS_BLOCK-1:0] act,
                       input logic [BITS_BLOCK-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_level();
    return (bq.size() + 1) / 2;
  endfunction

  task automatic model_update(input logic r, input logic iv, input block_t f0,
                              input block_t f1, input logic ir);
    bit was_full;
    if (r) begin
      bq.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = 1'b0;
      return;
    end
    was_full = (m_level() == DEPTH);
    if (!m_valid || ir) begin
      if (bq.size() > 0) begin
        m_data  = bq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (iv) begin
      if (was_full) m_ovf = 1'b1;
      else begin
        bq.push_back(f0);
        bq.push_back(f1);
      end
    end
  endtask

  task automatic compare_model();
    check("mdl_valid",    bus.valid,      m_valid);
    check("mdl_data",     bus.data_out,   m_data);
    check("mdl_level",    bus.fifo_level, m_level());
    check("mdl_o_ready",  bus.o_ready,    m_level() != DEPTH);
    check("mdl_overflow", bus.overflow,   m_ovf);
  endtask

  // One clock: drive inputs, clock edge, update model, compare at negedge.
  task automatic step(input logic r, input logic iv, input block_t f0,
                      input block_t f1, input logic ir);
    rst         = r;
    bus.i_valid = iv;
    bus.flow_0  = f0;
    bus.flow_1  = f1;
    bus.i_ready = ir;
    @(posedge clk);
    model_update(r, iv, f0, f1, ir);
    @(negedge clk);
    compare_model();
  endtask

  function automatic block_t rand_block();
    logic [287:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[BITS_BLOCK-1:0];
  endfunction

  typedef struct {
    logic          r;
    logic          iv;
    block_t        f0;
    block_t        f1;
    logic          ir;
    logic          e_valid;
    block_t        e_data;
    logic [CW-1:0] e_level;
    logic          e_ovf;
    logic          e_ordy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    block_t a0, a1, b0, b1, c0, c1;
    bit     saw_full;

    rst = 1'b1; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.flow_0 = '0; bus.flow_1 = '0;
    m_valid = 1'b0; m_data = '0; m_ovf = 1'b0;

    // Reset held with i_valid=1 stores nothing; then one pair 1/2 drains.
    vecs[0] = '{1'b1, 1'b1, 257'h5, 257'h6, 1'b1, 1'b0, 257'h0, 3'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 257'h5, 257'h6, 1'b1, 1'b0, 257'h0, 3'd0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 257'h5, 257'h6, 1'b1, 1'b0, 257'h0, 3'd0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 257'h1, 257'h2, 1'b1, 1'b0, 257'h0, 3'd1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 257'h0, 257'h0, 1'b1, 1'b1, 257'h1, 3'd1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 257'h0, 257'h0, 1'b1, 1'b1, 257'h2, 3'd0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 257'h0, 257'h0, 1'b1, 1'b0, 257'h2, 3'd0, 1'b0, 1'b1};

    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].r, vecs[i].iv, vecs[i].f0, vecs[i].f1, vecs[i].ir);
      check($sformatf("vec%0d_valid", i), bus.valid,      vecs[i].e_valid);
      check($sformatf("vec%0d_data", i),  bus.data_out,   vecs[i].e_data);
      check($sformatf("vec%0d_level", i), bus.fifo_level, vecs[i].e_level);
      check($sformatf("vec%0d_ovf", i),   bus.overflow,   vecs[i].e_ovf);
      check($sformatf("vec%0d_ordy", i),  bus.o_ready,    vecs[i].e_ordy);
    end

    // Paced stream: a pair every 2nd cycle yields contiguous 0..199.
    for (int k = 0; k < 100; k++) begin
      step(1'b0, 1'b1, block_t'(2*k), block_t'(2*k+1), 1'b1);
      if (k > 0) check("paced_seq", bus.data_out, block_t'(2*k-1));
      step(1'b0, 1'b0, '0, '0, 1'b1);
      check("paced_seq", bus.data_out, block_t'(2*k));
      check("paced_level_le1", bus.fifo_level <= 1, 1'b1);
    end
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check("paced_last", bus.data_out, block_t'(199));
    check("paced_no_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b1);

    // Overrun: a pair every cycle overfills the FIFO; overflow sticks.
    saw_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, rand_block(), rand_block(), 1'b1);
      if (!bus.o_ready) saw_full = 1'b1;
    end
    check("overrun_ordy_low", saw_full, 1'b1);
    check("overrun_ovf", bus.overflow, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
    check("overrun_ovf_sticky", bus.overflow, 1'b1);
    check("overrun_drained", bus.valid, 1'b0);

    // Backpressure stall while flow_1 of a pair sits on data_out.
    a0 = rand_block(); a1 = rand_block(); b0 = rand_block(); b1 = rand_block();
    step(1'b0, 1'b1, a0, a1, 1'b1);
    step(1'b0, 1'b1, b0, b1, 1'b1);
    check("stall_a0", bus.data_out, a0);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check("stall_a1", bus.data_out, a1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0);
      check("stall_hold_data", bus.data_out, a1);
      check("stall_hold_valid", bus.valid, 1'b1);
    end
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check("stall_release_b0", bus.data_out, b0);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check("stall_release_b1", bus.data_out, b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 1'b1);

    // Reset with three pairs stored and the head half-emitted.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand_block(), rand_block(), 1'b0);
    check("midrst_level3", bus.fifo_level, 3);
    step(1'b1, 1'b1, rand_block(), rand_block(), 1'b0);
    check("midrst_level0", bus.fifo_level, 0);
    check("midrst_valid0", bus.valid, 1'b0);
    check("midrst_data0",  bus.data_out, '0);
    c0 = rand_block(); c1 = rand_block();
    step(1'b0, 1'b1, c0, c1, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check("midrst_f0_first", bus.data_out, c0);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check("midrst_f1_second", bus.data_out, c1);

    // Randomized traffic with varying offer/accept rates and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int pv, pr;
      pv = 20 + 30 * ((i / 500) % 3);
      pr = 40 + 30 * ((i / 700) % 3);
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < pv), rand_block(), rand_block(),
           ($urandom_range(0, 99) < pr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
